traceback_unit: RTL and testbench

TRACEBACK_UNIT -- requirements
Module: traceback_unit

---
 rtl/traceback_if.sv | 23 ++
 rtl/traceback_unit.sv | 112 +++++++++++
 tb/tb_traceback_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/traceback_if.sv
// Column-in / bit-out handshake bundle for traceback_unit.
// master: the side that produces columns and consumes bits.
// slave:  the traceback unit itself.
interface traceback_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] surv0, surv1, surv2, surv3;
  logic [6:0] pm0, pm1, pm2, pm3;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;

  modport master (
    output in_valid, surv0, surv1, surv2, surv3, pm0, pm1, pm2, pm3, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, surv0, surv1, surv2, surv3, pm0, pm1, pm2, pm3, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/traceback_unit.sv
// Block-based Viterbi traceback for a 4-state trellis.
// Collects TB_LEN survivor columns, traces back once from the best end state,
// then streams the decoded bits oldest first.
// Optional macro TB_ZERO_START_EN: always start traceback from state 00
// (zero-tail terminated frames); path metrics are then ignored.
module traceback_unit #(
  parameter int TB_LEN = 8
) (
  input logic          clk,
  input logic          rst_n,
  traceback_if.slave   tb_bus
);

  localparam int PW = $clog2(TB_LEN);
  localparam logic [PW-1:0] LAST = PW'(TB_LEN - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_TRACE = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  logic [1:0]                     state;
  logic [PW-1:0]                  wr_ptr, tr_ptr, rd_ptr;
  logic [1:0]                     cur;
  logic [1:0]                     start_st;
  logic [TB_LEN-1:0][3:0][1:0]    mem;
  logic [TB_LEN-1:0]              dbit;
  logic                           in_fire, out_fire;

  assign tb_bus.in_ready  = (state == S_FILL);
  assign tb_bus.out_valid = (state == S_EMIT);
  assign tb_bus.out_bit   = (state == S_EMIT) ? dbit[rd_ptr] : 1'b0;
  assign tb_bus.out_last  = (state == S_EMIT) && (rd_ptr == LAST);

  assign in_fire  = tb_bus.in_valid  && tb_bus.in_ready;
  assign out_fire = tb_bus.out_valid && tb_bus.out_ready;

`ifdef TB_ZERO_START_EN
  logic unused_pm;
  assign unused_pm = ^{tb_bus.pm0, tb_bus.pm1, tb_bus.pm2, tb_bus.pm3};

  // Terminated frames always end in state 00.
  always_comb begin
    start_st = 2'd0;
  end
`else
  logic [6:0] best_pm;

  // Argmin of the incoming path metrics; strict '<' keeps ties on the lowest index.
  always_comb begin
    best_pm  = tb_bus.pm0;
    start_st = 2'd0;
    if (tb_bus.pm1 < best_pm) begin best_pm = tb_bus.pm1; start_st = 2'd1; end
    if (tb_bus.pm2 < best_pm) begin best_pm = tb_bus.pm2; start_st = 2'd2; end
    if (tb_bus.pm3 < best_pm) begin best_pm = tb_bus.pm3; start_st = 2'd3; end
  end
`endif

  // Survivor memory: one 4x2-bit column per accepted input, no reset needed.
  always_ff @(posedge clk) begin
    if (in_fire)
      mem[wr_ptr] <= {tb_bus.surv3, tb_bus.surv2, tb_bus.surv1, tb_bus.surv0};
  end

  // Decoded bits captured during traceback; bit i is the MSB of the state at column i.
  always_ff @(posedge clk) begin
    if (state == S_TRACE)
      dbit[tr_ptr] <= cur[1];
  end

  // Control FSM: FILL -> TRACE (TB_LEN cycles) -> EMIT -> FILL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_FILL;
      wr_ptr <= '0;
      tr_ptr <= '0;
      rd_ptr <= '0;
      cur    <= 2'd0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_fire) begin
            if (wr_ptr == LAST) begin
              wr_ptr <= '0;
              cur    <= start_st;
              tr_ptr <= LAST;
              state  <= S_TRACE;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        S_TRACE: begin
          cur <= mem[tr_ptr][cur];
          if (tr_ptr == '0) state  <= S_EMIT;
          else              tr_ptr <= tr_ptr - PW'(1);
        end
        S_EMIT: begin
          if (out_fire) begin
            if (rd_ptr == LAST) begin
              rd_ptr <= '0;
              state  <= S_FILL;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed, table-driven bench for traceback_unit at TB_LEN=4.
module tb_traceback_unit;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  traceback_if bus ();

  traceback_unit #(.TB_LEN(L)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tb_bus (bus)
  );

  typedef struct {
    logic [3:0][3:0][1:0] s;      // s[col][state] = predecessor
    logic [3:0][6:0]      pm;     // last-column metrics, pm[k] = pmk
    logic [3:0]           exp_nz; // exp[k] = k-th emitted bit, metric start
    logic [3:0]           exp_z;  // same, zero-start build
    int                   stall_bit;
    int                   stall_n;
  } vec_t;

  vec_t vt[5];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_of(input vec_t v);
`ifdef TB_ZERO_START_EN
    return v.exp_z;
`else
    return v.exp_nz;
`endif
  endfunction

  // Drive four columns; earlier columns carry decoy metrics favouring state 01.
  task automatic send_block(input vec_t v);
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      chk("in_ready_fill", bus.in_ready, 1);
      chk("out_valid_fill", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.surv0 = v.s[c][0]; bus.surv1 = v.s[c][1];
      bus.surv2 = v.s[c][2]; bus.surv3 = v.s[c][3];
      if (c == L - 1) begin
        bus.pm0 = v.pm[0]; bus.pm1 = v.pm[1]; bus.pm2 = v.pm[2]; bus.pm3 = v.pm[3];
      end else begin
        bus.pm0 = 7'd100; bus.pm1 = 7'd0; bus.pm2 = 7'd100; bus.pm3 = 7'd100;
      end
    end
  endtask

  // Wait for the first output bit with garbage columns and out_ready toggling, then collect.
  task automatic run_block(input vec_t v);
    int n, got, stalled, guard;
    logic [3:0] e;
    e = exp_of(v);
    send_block(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.out_ready = n[0];
      bus.surv0 = 2'($urandom_range(0, 3)); bus.surv1 = 2'($urandom_range(0, 3));
      bus.surv2 = 2'($urandom_range(0, 3)); bus.surv3 = 2'($urandom_range(0, 3));
      bus.pm0 = 7'($urandom_range(0, 127)); bus.pm3 = 7'($urandom_range(0, 127));
      if (!bus.out_valid) begin
        chk("in_ready_trace", bus.in_ready, 0);
        chk("out_bit_trace", bus.out_bit, 0);
      end
    end while (!bus.out_valid && n < 40);
    chk("latency", n, L + 1);
    got = 0; stalled = 0; guard = 0;
    while (got < L && guard < 60) begin
      guard++;
      if (bus.out_valid) begin
        chk("out_bit", bus.out_bit, e[got]);
        chk("out_last", bus.out_last, (got == L - 1) ? 1 : 0);
        chk("in_ready_emit", bus.in_ready, 0);
        if (got == v.stall_bit && stalled < v.stall_n) begin
          bus.out_ready = 1'b0;
          stalled++;
        end else begin
          bus.out_ready = 1'b1;
          got++;
        end
      end else begin
        chk("out_valid_gap", bus.out_valid, 1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    chk("bit_count", got, L);
    chk("stall_count", stalled, v.stall_n);
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_out_last", bus.out_last, 0);
  endtask

  initial begin
    // Vector table
    for (int i = 0; i < 5; i++) begin
      vt[i].s = '0; vt[i].pm = '0; vt[i].stall_bit = -1; vt[i].stall_n = 0;
    end
    // 0: all survivors 00, min at pm0 -> zeros
    vt[0].pm[0] = 7'd0; vt[0].pm[1] = 7'd9; vt[0].pm[2] = 7'd9; vt[0].pm[3] = 7'd9;
    vt[0].exp_nz = 4'b0000; vt[0].exp_z = 4'b0000;
    // 1: start 11 -> bits 1,0,1,1
    vt[1].s[0][2] = 2'b00; vt[1].s[1][1] = 2'b10; vt[1].s[2][2] = 2'b01; vt[1].s[3][3] = 2'b10;
    vt[1].pm[0] = 7'd9; vt[1].pm[1] = 7'd9; vt[1].pm[2] = 7'd9; vt[1].pm[3] = 7'd0;
    vt[1].exp_nz = 4'b1101; vt[1].exp_z = 4'b0000;
    // 2: same survivors, all metrics tied -> start 00
    vt[2].s = vt[1].s;
    vt[2].pm[0] = 7'd4; vt[2].pm[1] = 7'd4; vt[2].pm[2] = 7'd4; vt[2].pm[3] = 7'd4;
    vt[2].exp_nz = 4'b0000; vt[2].exp_z = 4'b0000;
    // 3: tie between 10 and 11 with large others -> start 10 -> bits 0,0,0,1
    vt[3].s = vt[1].s;
    vt[3].pm[0] = 7'd127; vt[3].pm[1] = 7'd127; vt[3].pm[2] = 7'd3; vt[3].pm[3] = 7'd3;
    vt[3].exp_nz = 4'b1000; vt[3].exp_z = 4'b0000;
    // 4: all survivors 11, start 01 -> bits 1,1,1,0; backpressure on 2nd bit
    for (int c = 0; c < 4; c++)
      for (int st = 0; st < 4; st++) vt[4].s[c][st] = 2'b11;
    vt[4].pm[0] = 7'd6; vt[4].pm[1] = 7'd2; vt[4].pm[2] = 7'd100; vt[4].pm[3] = 7'd2;
    vt[4].exp_nz = 4'b0111; vt[4].exp_z = 4'b0111;
    vt[4].stall_bit = 1; vt[4].stall_n = 3;

    // Reset
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.surv0 = '0; bus.surv1 = '0; bus.surv2 = '0; bus.surv3 = '0;
    bus.pm0 = '0; bus.pm1 = '0; bus.pm2 = '0; bus.pm3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_bit", bus.out_bit, 0);
    chk("rst_out_last", bus.out_last, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_block(vt[i]);

    // Reset on the second TRACE cycle aborts the block
    send_block(vt[1]);
    @(negedge clk);
    chk("abort_trace1_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_bit", bus.out_bit, 0);
    chk("abort_out_last", bus.out_last, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_out_valid", bus.out_valid, 0);
    end
    run_block(vt[1]);
    run_block(vt[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
